// File: rtl/img_downscale_engine_pkg.sv
// ============================================================================
//  Module      : img_pkg
//  Description : Shared types and constants for the image downscale engine.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package img_pkg;

    localparam int ADDR_W = 19;
    localparam int PIX_W  = 8;
    localparam int ACC_W  = 12;

    localparam logic [1:0] MODE_COPY = 2'b00;
    localparam logic [1:0] MODE_DEC  = 2'b01;
    localparam logic [1:0] MODE_MEAN = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_WAIT  = 3'd2,
        S_ACC   = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Scale factor 4 maps to shift 2; every other encoding behaves as factor 2.
    function automatic logic [1:0] fator_log2(input logic [2:0] fator);
        return (fator == 3'd4) ? 2'd2 : 2'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/img_downscale_engine_block_scan_ctr.sv
// ============================================================================
//  Module      : block_scan_ctr
//  Description : Nested ox/oy/i/j scan counters producing source and
//                destination pixel addresses.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module block_scan_ctr
    import img_pkg::*;
#(
    parameter int SRC_W = 160,
    parameter int SRC_H = 120
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic [1:0]        i_f_log,
    input  logic              i_block_scan,
    input  logic              i_step_src,
    input  logic              i_step_dst,
    output logic [ADDR_W-1:0] o_src_addr,
    output logic [ADDR_W-1:0] o_dst_addr,
    output logic              o_last_sample,
    output logic              o_last_dst
);

    localparam int c_XW = $clog2(SRC_W + 1);
    localparam int c_YW = $clog2(SRC_H + 1);

    logic [c_XW-1:0]   r_ox;
    logic [c_YW-1:0]   r_oy;
    logic [1:0]        r_i;
    logic [1:0]        r_j;
    logic [ADDR_W-1:0] r_dst;

    logic [c_XW-1:0]   w_ow;
    logic [c_YW-1:0]   w_oh;
    logic [1:0]        w_span_m1;
    logic [ADDR_W-1:0] w_x;
    logic [ADDR_W-1:0] w_y;
    logic [ADDR_W-1:0] w_total;
    logic              w_last_i;
    logic              w_last_j;
    logic              w_last_ox;
    logic              w_last_oy;

    // Output dimensions truncate, so partial edge blocks are never visited.
    assign w_ow = c_XW'(SRC_W >> i_f_log);
    assign w_oh = c_YW'(SRC_H >> i_f_log);

    assign w_span_m1 = !i_block_scan    ? 2'd0 :
                       (i_f_log == 2'd2) ? 2'd3 :
                       (i_f_log == 2'd1) ? 2'd1 : 2'd0;

    assign w_last_i  = (r_i == w_span_m1);
    assign w_last_j  = (r_j == w_span_m1);
    assign w_last_ox = (r_ox == w_ow - 1'b1);
    assign w_last_oy = (r_oy == w_oh - 1'b1);

    assign w_x = (ADDR_W'(r_ox) << i_f_log) + ADDR_W'(r_i);
    assign w_y = (ADDR_W'(r_oy) << i_f_log) + ADDR_W'(r_j);

    assign w_total = ADDR_W'(w_ow) * ADDR_W'(w_oh);

    assign o_src_addr    = w_y * ADDR_W'(SRC_W) + w_x;
    assign o_dst_addr    = r_dst;
    assign o_last_sample = w_last_i & w_last_j;
    assign o_last_dst    = (r_dst == w_total - 1'b1);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ox  <= '0;
            r_oy  <= '0;
            r_i   <= '0;
            r_j   <= '0;
            r_dst <= '0;
        end else begin
            if (i_step_src) begin
                if (!w_last_i) begin
                    r_i <= r_i + 2'd1;
                end else begin
                    r_i <= '0;
                    if (!w_last_j) begin
                        r_j <= r_j + 2'd1;
                    end else begin
                        r_j <= '0;
                        if (!w_last_ox) begin
                            r_ox <= r_ox + 1'b1;
                        end else begin
                            r_ox <= '0;
                            r_oy <= w_last_oy ? '0 : r_oy + 1'b1;
                        end
                    end
                end
            end
            // The destination freezes on the final pixel so DONE holds it.
            if (i_step_dst && !o_last_dst) begin
                r_dst <= r_dst + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/img_downscale_engine.sv
// ============================================================================
//  Module      : img_downscale_engine
//  Description : Single-pass ROM-to-RAM image copy / decimation / block mean.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module img_downscale_engine
    import img_pkg::*;
#(
    parameter int SRC_W       = 160,
    parameter int SRC_H       = 120,
    parameter int ROM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic [2:0]        fator,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [PIX_W-1:0]  rom_data,
    output logic [ADDR_W-1:0] ram_wraddr,
    output logic [PIX_W-1:0]  ram_data,
    output logic              ram_wren,
    output logic              done
);

    localparam int c_WAIT_W = (ROM_LATENCY > 2) ? $clog2(ROM_LATENCY) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST =
        c_WAIT_W'((ROM_LATENCY >= 2) ? ROM_LATENCY - 2 : 0);

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          r_flog;
    logic                r_mean;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [ACC_W-1:0]    r_acc;
    logic [PIX_W-1:0]    r_ram_data;
    logic [ADDR_W-1:0]   r_rom_addr;
    logic                r_last_sample;

    logic [ACC_W-1:0]    w_sum;
    logic [2:0]          w_shift;
    logic [PIX_W-1:0]    w_result;
    logic [ADDR_W-1:0]   w_src_addr;
    logic [ADDR_W-1:0]   w_dst_addr;
    logic                w_last_sample;
    logic                w_last_dst;
    logic                w_step_src;
    logic                w_step_dst;

    block_scan_ctr #(
        .SRC_W (SRC_W),
        .SRC_H (SRC_H)
    ) u_scan (
        .clk           (clk),
        .i_rst_n       (reset),
        .i_f_log       (r_flog),
        .i_block_scan  (r_mean),
        .i_step_src    (w_step_src),
        .i_step_dst    (w_step_dst),
        .o_src_addr    (w_src_addr),
        .o_dst_addr    (w_dst_addr),
        .o_last_sample (w_last_sample),
        .o_last_dst    (w_last_dst)
    );

    // Counters advance while the sample address is on the bus, so they
    // already point at the next sample when ADDR is re-entered.
    assign w_step_src = (r_state == S_ADDR);
    assign w_step_dst = (r_state == S_WRITE);

    assign w_sum    = r_acc + ACC_W'(rom_data);
    assign w_shift  = r_mean ? {r_flog, 1'b0} : 3'd0;
    assign w_result = PIX_W'(w_sum >> w_shift);

    assign rom_addr   = r_rom_addr;
    assign ram_wraddr = w_dst_addr;
    assign ram_data   = r_ram_data;

    always_comb begin
        w_next   = r_state;
        ram_wren = 1'b0;
        done     = 1'b0;
        unique case (r_state)
            S_IDLE:  w_next = (mode == MODE_RSVD) ? S_DONE : S_ADDR;
            S_ADDR:  w_next = (ROM_LATENCY > 1) ? S_WAIT : S_ACC;
            S_WAIT: begin
                if (r_wait_cnt == c_WAIT_LAST) begin
                    w_next = S_ACC;
                end
            end
            S_ACC:   w_next = r_last_sample ? S_WRITE : S_ADDR;
            S_WRITE: begin
                ram_wren = 1'b1;
                w_next   = w_last_dst ? S_DONE : S_ADDR;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_flog        <= '0;
            r_mean        <= 1'b0;
            r_wait_cnt    <= '0;
            r_acc         <= '0;
            r_ram_data    <= '0;
            r_rom_addr    <= '0;
            r_last_sample <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE) begin
                r_flog <= (mode == MODE_COPY) ? 2'd0 : fator_log2(fator);
                r_mean <= (mode == MODE_MEAN);
            end
            r_wait_cnt <= (r_state == S_WAIT) ? r_wait_cnt + 1'b1 : '0;
            if (w_next == S_ADDR) begin
                r_rom_addr <= w_src_addr;
            end
            if (r_state == S_ADDR) begin
                r_last_sample <= w_last_sample;
            end
            if (r_state == S_ACC) begin
                r_acc <= w_sum;
                if (r_last_sample) begin
                    r_ram_data <= w_result;
                end
            end else if (r_state == S_WRITE) begin
                r_acc <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_img_downscale_engine.sv
// ============================================================================
//  Module      : tb_img_downscale_engine
//  Description : Self-checking bench for img_downscale_engine on an 8x4 image.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_img_downscale_engine;

    localparam int c_SRC_W = 8;
    localparam int c_SRC_H = 4;
    localparam int c_LAT   = 2;
    localparam int c_NPIX  = c_SRC_W * c_SRC_H;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  mode  = 2'b00;
    logic [2:0]  fator = 3'd2;
    logic [18:0] rom_addr;
    logic [7:0]  rom_data;
    logic [18:0] ram_wraddr;
    logic [7:0]  ram_data;
    logic        ram_wren;
    logic        done;

    logic [7:0]  rom_mem [0:c_NPIX-1];
    logic [7:0]  rom_d1 = 8'd0;
    logic [7:0]  rom_d2 = 8'd0;

    int n_checks = 0;
    int n_pass   = 0;

    int obs_addr[$];
    int obs_data[$];
    int obs_cyc[$];
    int done_cyc;
    int post_done_wr;
    int rom_oob;

    int exp_addr[$];
    int exp_data[$];
    int exp_cyc[$];

    always #5 clk = ~clk;

    // Two-clock ROM: data for the address seen at one edge appears two edges later.
    always @(posedge clk) begin
        rom_d1 <= rom_mem[rom_addr[4:0]];
        rom_d2 <= rom_d1;
    end
    assign rom_data = rom_d2;

    img_downscale_engine #(
        .SRC_W       (c_SRC_W),
        .SRC_H       (c_SRC_H),
        .ROM_LATENCY (c_LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mode       (mode),
        .fator      (fator),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .ram_wraddr (ram_wraddr),
        .ram_data   (ram_data),
        .ram_wren   (ram_wren),
        .done       (done)
    );

    // kind 0: pixel = address, kind 1: all 255, kind 2: random
    task automatic fill_rom(input int kind);
        for (int a = 0; a < c_NPIX; a++) begin
            if (kind == 0)      rom_mem[a] = 8'(a);
            else if (kind == 1) rom_mem[a] = 8'hFF;
            else                rom_mem[a] = 8'($urandom);
        end
    endtask

    // Expected writes straight from the image-level definition of each mode.
    function automatic void build_expected(input logic [1:0] m, input logic [2:0] f_in);
        int f, n, ow, oh, per, k, sum;
        exp_addr.delete();
        exp_data.delete();
        exp_cyc.delete();
        if (m == 2'b11) return;
        f   = (m == 2'b00) ? 1 : ((f_in == 3'd4) ? 4 : 2);
        n   = (m == 2'b10) ? f : 1;
        ow  = c_SRC_W / f;
        oh  = c_SRC_H / f;
        per = n * n * (c_LAT + 1) + 1;
        k   = 0;
        for (int oy = 0; oy < oh; oy++) begin
            for (int ox = 0; ox < ow; ox++) begin
                sum = 0;
                for (int j = 0; j < n; j++)
                    for (int i = 0; i < n; i++)
                        sum += int'(rom_mem[(oy * f + j) * c_SRC_W + ox * f + i]);
                exp_addr.push_back(oy * ow + ox);
                exp_data.push_back(sum / (n * n));
                exp_cyc.push_back((k + 1) * per);
                k++;
            end
        end
    endfunction

    // Reset, release, then record every write until a few clocks past done.
    task automatic run_pass(input logic [1:0] m, input logic [2:0] f,
                            input bit scramble, input int budget);
        reset = 1'b0;
        mode  = m;
        fator = f;
        obs_addr.delete();
        obs_data.delete();
        obs_cyc.delete();
        done_cyc     = -1;
        post_done_wr = 0;
        rom_oob      = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            if (scramble) begin
                mode  = 2'($urandom);
                fator = 3'($urandom);
            end
            if (ram_wren) begin
                if (done_cyc < 0) begin
                    obs_addr.push_back(int'(ram_wraddr));
                    obs_data.push_back(int'(ram_data));
                    obs_cyc.push_back(cyc);
                end else begin
                    post_done_wr++;
                end
            end
            if (int'(rom_addr) >= c_NPIX) rom_oob++;
            if (done && done_cyc < 0) done_cyc = cyc;
            if (done_cyc >= 0 && cyc >= done_cyc + 6) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (rom_addr !== '0)   $display("FAIL reset_rom_addr: got %0d expected 0", rom_addr); else n_pass++;
        n_checks++; if (ram_wraddr !== '0) $display("FAIL reset_ram_wraddr: got %0d expected 0", ram_wraddr); else n_pass++;
        n_checks++; if (ram_data !== '0)   $display("FAIL reset_ram_data: got %0d expected 0", ram_data); else n_pass++;
        n_checks++; if (ram_wren !== 1'b0) $display("FAIL reset_ram_wren: got %b expected 0", ram_wren); else n_pass++;
        n_checks++; if (done !== 1'b0)     $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
    endtask

    task automatic test_copy();
        logic [2:0] f;
        f = 3'($urandom);
        fill_rom(0);
        build_expected(2'b00, f);
        run_pass(2'b00, f, 1'b0, 400);
        n_checks++; if (done_cyc < 0) $display("FAIL copy_done_timeout: done never rose"); else n_pass++;
        n_checks++; if (obs_addr.size() != 32) $display("FAIL copy_count: got %0d expected 32", obs_addr.size()); else n_pass++;
        for (int k = 0; k < exp_addr.size() && k < obs_addr.size(); k++) begin
            n_checks++; if (obs_addr[k] != exp_addr[k]) $display("FAIL copy_addr[%0d]: got %0d expected %0d", k, obs_addr[k], exp_addr[k]); else n_pass++;
            n_checks++; if (obs_data[k] != exp_data[k]) $display("FAIL copy_data[%0d]: got %0d expected %0d", k, obs_data[k], exp_data[k]); else n_pass++;
            n_checks++; if (obs_cyc[k] != exp_cyc[k])   $display("FAIL copy_cycle[%0d]: got %0d expected %0d", k, obs_cyc[k], exp_cyc[k]); else n_pass++;
        end
        n_checks++; if (done_cyc != exp_cyc[exp_cyc.size()-1] + 1) $display("FAIL copy_done_cycle: got %0d expected %0d", done_cyc, exp_cyc[exp_cyc.size()-1] + 1); else n_pass++;
        n_checks++; if (post_done_wr != 0) $display("FAIL copy_write_after_done: got %0d expected 0", post_done_wr); else n_pass++;
        n_checks++; if (rom_oob != 0) $display("FAIL copy_rom_bound: got %0d expected 0", rom_oob); else n_pass++;
    endtask

    task automatic test_decimation();
        int spec_vals [8] = '{0, 2, 4, 6, 16, 18, 20, 22};
        fill_rom(0);
        build_expected(2'b01, 3'd2);
        run_pass(2'b01, 3'd2, 1'b0, 200);
        n_checks++; if (obs_addr.size() != 8) $display("FAIL dec_count: got %0d expected 8", obs_addr.size()); else n_pass++;
        for (int k = 0; k < 8 && k < obs_addr.size(); k++) begin
            n_checks++; if (obs_data[k] != spec_vals[k]) $display("FAIL dec_data[%0d]: got %0d expected %0d", k, obs_data[k], spec_vals[k]); else n_pass++;
            n_checks++; if (obs_addr[k] != exp_addr[k])  $display("FAIL dec_addr[%0d]: got %0d expected %0d", k, obs_addr[k], exp_addr[k]); else n_pass++;
            n_checks++; if (obs_cyc[k] != exp_cyc[k])    $display("FAIL dec_cycle[%0d]: got %0d expected %0d", k, obs_cyc[k], exp_cyc[k]); else n_pass++;
        end
        n_checks++; if (post_done_wr != 0) $display("FAIL dec_write_after_done: got %0d expected 0", post_done_wr); else n_pass++;
    endtask

    task automatic test_mean_f2();
        fill_rom(0);
        build_expected(2'b10, 3'd2);
        run_pass(2'b10, 3'd2, 1'b0, 400);
        n_checks++; if (obs_addr.size() != 8) $display("FAIL mean2_count: got %0d expected 8", obs_addr.size()); else n_pass++;
        if (obs_data.size() >= 2) begin
            n_checks++; if (obs_data[0] != 4) $display("FAIL mean2_first: got %0d expected 4", obs_data[0]); else n_pass++;
            n_checks++; if (obs_data[1] != 6) $display("FAIL mean2_second: got %0d expected 6", obs_data[1]); else n_pass++;
        end
        for (int k = 0; k < exp_addr.size() && k < obs_addr.size(); k++) begin
            n_checks++; if (obs_addr[k] != exp_addr[k]) $display("FAIL mean2_addr[%0d]: got %0d expected %0d", k, obs_addr[k], exp_addr[k]); else n_pass++;
            n_checks++; if (obs_data[k] != exp_data[k]) $display("FAIL mean2_data[%0d]: got %0d expected %0d", k, obs_data[k], exp_data[k]); else n_pass++;
            n_checks++; if (obs_cyc[k] != exp_cyc[k])   $display("FAIL mean2_cycle[%0d]: got %0d expected %0d", k, obs_cyc[k], exp_cyc[k]); else n_pass++;
        end
        n_checks++; if (rom_oob != 0) $display("FAIL mean2_rom_bound: got %0d expected 0", rom_oob); else n_pass++;
    endtask

    task automatic test_mean_f4_full_scale();
        fill_rom(1);
        run_pass(2'b10, 3'd4, 1'b0, 400);
        n_checks++; if (obs_addr.size() != 2) $display("FAIL mean4_count: got %0d expected 2", obs_addr.size()); else n_pass++;
        for (int k = 0; k < 2 && k < obs_addr.size(); k++) begin
            n_checks++; if (obs_data[k] != 255) $display("FAIL mean4_data[%0d]: got %0d expected 255", k, obs_data[k]); else n_pass++;
            n_checks++; if (obs_addr[k] != k)   $display("FAIL mean4_addr[%0d]: got %0d expected %0d", k, obs_addr[k], k); else n_pass++;
        end
        // first ADDR is clock 1, so done lands 2*(16*3+1) clocks later
        n_checks++; if (done_cyc != 1 + 2 * (16 * 3 + 1)) $display("FAIL mean4_done_cycle: got %0d expected %0d", done_cyc, 1 + 2 * (16 * 3 + 1)); else n_pass++;
        n_checks++; if (rom_oob != 0) $display("FAIL mean4_rom_bound: got %0d expected 0", rom_oob); else n_pass++;
    endtask

    task automatic test_reset_midpass();
        int nwr;
        fill_rom(0);
        reset = 1'b0;
        mode  = 2'b00;
        fator = 3'd2;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        nwr = 0;
        for (int cyc = 1; cyc <= 200 && nwr < 11; cyc++) begin
            @(negedge clk);
            if (ram_wren) nwr++;
        end
        n_checks++; if (nwr != 11) $display("FAIL midreset_reach_pixel10: got %0d writes expected 11", nwr); else n_pass++;
        n_checks++; if (ram_wraddr !== 19'd10) $display("FAIL midreset_pre_wraddr: got %0d expected 10", ram_wraddr); else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_checks++; if (rom_addr !== '0)   $display("FAIL midreset_rom_addr: got %0d expected 0", rom_addr); else n_pass++;
        n_checks++; if (ram_wraddr !== '0) $display("FAIL midreset_ram_wraddr: got %0d expected 0", ram_wraddr); else n_pass++;
        n_checks++; if (ram_data !== '0)   $display("FAIL midreset_ram_data: got %0d expected 0", ram_data); else n_pass++;
        n_checks++; if (ram_wren !== 1'b0) $display("FAIL midreset_ram_wren: got %b expected 0", ram_wren); else n_pass++;
        n_checks++; if (done !== 1'b0)     $display("FAIL midreset_done: got %b expected 0", done); else n_pass++;
        build_expected(2'b00, 3'd2);
        run_pass(2'b00, 3'd2, 1'b0, 400);
        n_checks++; if (obs_addr.size() != 32) $display("FAIL midreset_restart_count: got %0d expected 32", obs_addr.size()); else n_pass++;
        if (obs_addr.size() > 0) begin
            n_checks++; if (obs_addr[0] != 0) $display("FAIL midreset_restart_addr: got %0d expected 0", obs_addr[0]); else n_pass++;
            n_checks++; if (obs_data[0] != exp_data[0]) $display("FAIL midreset_restart_data: got %0d expected %0d", obs_data[0], exp_data[0]); else n_pass++;
            n_checks++; if (obs_cyc[0] != c_LAT + 2) $display("FAIL midreset_first_write_cycle: got %0d expected %0d", obs_cyc[0], c_LAT + 2); else n_pass++;
        end
    endtask

    task automatic test_mode_reserved();
        int nwr;
        int addr_moves;
        reset = 1'b0;
        mode  = 2'b11;
        fator = 3'd4;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++; if (done !== 1'b0) $display("FAIL rsvd_done_in_idle: got %b expected 0", done); else n_pass++;
        @(negedge clk);
        n_checks++; if (done !== 1'b1) $display("FAIL rsvd_done_second_clock: got %b expected 1", done); else n_pass++;
        nwr = 0;
        addr_moves = 0;
        repeat (12) begin
            @(negedge clk);
            mode = 2'($urandom);
            if (ram_wren) nwr++;
            if (rom_addr !== '0 || done !== 1'b1) addr_moves++;
        end
        n_checks++; if (nwr != 0) $display("FAIL rsvd_writes: got %0d expected 0", nwr); else n_pass++;
        n_checks++; if (addr_moves != 0) $display("FAIL rsvd_terminal: got %0d bad clocks expected 0", addr_moves); else n_pass++;
    endtask

    task automatic test_random_mode_changes();
        logic [1:0] m;
        logic [2:0] f;
        int bad;
        for (int it = 0; it < 6; it++) begin
            m = 2'($urandom_range(0, 2));
            f = 3'($urandom_range(0, 7));
            fill_rom(2);
            build_expected(m, f);
            run_pass(m, f, 1'b1, 2000);
            bad = 0;
            n_checks++; if (obs_addr.size() != exp_addr.size()) $display("FAIL rand%0d_count: mode %0d fator %0d got %0d expected %0d", it, m, f, obs_addr.size(), exp_addr.size()); else n_pass++;
            for (int k = 0; k < exp_addr.size() && k < obs_addr.size(); k++) begin
                if (obs_addr[k] != exp_addr[k] || obs_data[k] != exp_data[k] || obs_cyc[k] != exp_cyc[k]) begin
                    if (bad == 0)
                        $display("FAIL rand%0d_write[%0d]: got addr %0d data %0d cyc %0d expected addr %0d data %0d cyc %0d",
                                 it, k, obs_addr[k], obs_data[k], obs_cyc[k], exp_addr[k], exp_data[k], exp_cyc[k]);
                    bad++;
                end
            end
            n_checks++; if (bad != 0) $display("FAIL rand%0d_mismatches: got %0d expected 0", it, bad); else n_pass++;
            n_checks++; if (done_cyc != exp_cyc[exp_cyc.size()-1] + 1) $display("FAIL rand%0d_done_cycle: got %0d expected %0d", it, done_cyc, exp_cyc[exp_cyc.size()-1] + 1); else n_pass++;
            n_checks++; if (post_done_wr != 0 || rom_oob != 0) $display("FAIL rand%0d_after_done_or_bound: got %0d/%0d expected 0/0", it, post_done_wr, rom_oob); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_copy();
        test_decimation();
        test_mean_f2();
        test_mean_f4_full_scale();
        test_reset_midpass();
        test_mode_reserved();
        test_random_mode_changes();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
